// File: rtl/common_pkg.sv
// common: project-wide shared types.
package common;
    typedef logic [4:0] creg_addr_t;
endpackage

// File: rtl/pipeline_pkg.sv
// pipeline: issue-stage FSM states and the default in-flight limit.
package pipeline;
    localparam int DEF_MAX_INFLIGHT = 4;
    typedef enum logic [1:0] {RUN, DRAIN, CSR_BUSY} issue_state_t;
endpackage

// File: rtl/sb_counter_bank.sv
// sb_counter_bank: 32 two-bit pending-write counters; x0 stays at zero.
module sb_counter_bank
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_en_i,
    input  creg_addr_t inc_addr_i,
    input  logic       dec_en_i,
    input  creg_addr_t dec_addr_i,
    input  creg_addr_t rd_a_addr_i,
    input  creg_addr_t rd_b_addr_i,
    input  creg_addr_t sat_addr_i,
    output logic [1:0] rd_a_o,
    output logic [1:0] rd_b_o,
    output logic       sat_o
);
    logic [31:0][1:0] cnt_q, cnt_d;

    // A matching increment and decrement cancel, leaving the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < 32; i++)
            cnt_d[i] = cnt_q[i] + 2'(inc_en_i && inc_addr_i == 5'(i)) - 2'(dec_en_i && dec_addr_i == 5'(i));
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign rd_a_o = cnt_q[rd_a_addr_i];
    assign rd_b_o = cnt_q[rd_b_addr_i];
    assign sat_o  = cnt_q[sat_addr_i] == 2'd3;

    assert property (@(posedge clk) disable iff (reset) dec_en_i |-> cnt_q[dec_addr_i] != 2'd0);
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-stage issue gate with RAW scoreboard, in-flight cap and CSR serialization.
module issue_ctrl
    import common::*;
    import pipeline::*;
#(
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_valid,
    input  creg_addr_t dec_rs1,
    input  creg_addr_t dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    input  logic       dec_wen,
    input  creg_addr_t dec_dst,
    input  logic       dec_is_csr,
    input  logic       flush,
    input  logic       ret_valid,
    input  logic       ret_wen,
    input  creg_addr_t ret_dst,
    input  logic       ret_is_csr,
    output logic       issue_ready,
    output logic       stall_raw,
    output logic       stall_csr,
    output logic [2:0] inflight
);
    issue_state_t state_q, state_d;
    logic [2:0] inflight_q, inflight_d;
    logic [1:0] rs1_cnt, rs2_cnt;
    logic       dst_sat, raw, cap, ser, ready, fire;

    sb_counter_bank u_sb (
        .clk         (clk),
        .reset       (reset),
        .inc_en_i    (fire & dec_wen & (dec_dst != '0)),
        .inc_addr_i  (dec_dst),
        .dec_en_i    (ret_valid & ret_wen & (ret_dst != '0)),
        .dec_addr_i  (ret_dst),
        .rd_a_addr_i (dec_rs1),
        .rd_b_addr_i (dec_rs2),
        .sat_addr_i  (dec_dst),
        .rd_a_o      (rs1_cnt),
        .rd_b_o      (rs2_cnt),
        .sat_o       (dst_sat)
    );

    assign raw = (dec_use_rs1 & |rs1_cnt) | (dec_use_rs2 & |rs2_cnt);
    assign cap = (dec_wen & dst_sat) | (inflight_q == 3'(MAX_INFLIGHT));

    // ser marks a CSR-serialization block; ready is the unreset issue permission.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        ser     = 1'b0;
        case (state_q)
            RUN:
                if (dec_valid & dec_is_csr & |inflight_q) begin
                    ser = 1'b1;
                    if (!flush) state_d = DRAIN;
                end else begin
                    ready = ~raw & ~cap;
                    if (dec_valid & dec_is_csr & ready & ~flush) state_d = CSR_BUSY;
                end
            DRAIN: begin
                ser   = |inflight_q;
                ready = ~|inflight_q & ~raw;
                state_d = flush ? RUN : (dec_valid & ready) ? CSR_BUSY : DRAIN;
            end
            CSR_BUSY: begin
                ser = 1'b1;
                if (ret_valid & ret_is_csr) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign issue_ready = ready & ~reset;
    assign stall_raw   = dec_valid & raw & ~reset;
    assign stall_csr   = dec_valid & (ser | cap) & ~reset;
    assign fire        = dec_valid & issue_ready & ~flush;
    assign inflight_d  = inflight_q + 3'(fire) - 3'(ret_valid);
    assign inflight    = inflight_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q    <= RUN;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end

    assert property (@(posedge clk) disable iff (reset) ret_valid |-> inflight_q != 3'd0);
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dec_valid = 1'b0, dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0, dec_wen = 1'b0, dec_is_csr = 1'b0, flush = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_dst = '0, ret_dst = '0;
    logic       ret_valid = 1'b0, ret_wen = 1'b0, ret_is_csr = 1'b0;
    logic       issue_ready, stall_raw, stall_csr;
    logic [2:0] inflight;
    int         checks = 0;
    int         failures = 0;
    int         step_no = 0;

    typedef struct {
        int         id;
        logic       rdy, raw, csr;
        logic [2:0] inf;
    } exp_t;
    exp_t exp_q[$];

    issue_ctrl dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wen(dec_wen), .dec_dst(dec_dst),
        .dec_is_csr(dec_is_csr), .flush(flush), .ret_valid(ret_valid), .ret_wen(ret_wen),
        .ret_dst(ret_dst), .ret_is_csr(ret_is_csr), .issue_ready(issue_ready), .stall_raw(stall_raw),
        .stall_csr(stall_csr), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL step %0d %s actual=%0d expected=%0d", id, name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "issue_ready", int'(issue_ready), int'(e.rdy));
            chk(e.id, "stall_raw", int'(stall_raw), int'(e.raw));
            chk(e.id, "stall_csr", int'(stall_csr), int'(e.csr));
            chk(e.id, "inflight", int'(inflight), int'(e.inf));
        end

    // One cycle: drive inputs, queue expected outputs for this cycle, advance past the edge.
    task automatic step(input logic rst, v, csr, fl, u1, input int rs1, input logic u2, input int rs2,
                        input logic wen, input int dst, input logic rv, rwen, input int rdst, input logic rcsr,
                        input logic erdy, eraw, ecsr, input int einf);
        reset = rst; dec_valid = v; dec_is_csr = csr; flush = fl;
        dec_use_rs1 = u1; dec_rs1 = 5'(rs1); dec_use_rs2 = u2; dec_rs2 = 5'(rs2);
        dec_wen = wen; dec_dst = 5'(dst);
        ret_valid = rv; ret_wen = rwen; ret_dst = 5'(rdst); ret_is_csr = rcsr;
        exp_q.push_back('{step_no, erdy, eraw, ecsr, 3'(einf)});
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        //   rst v csr fl u1 rs1 u2 rs2 wen dst rv rw rdst rc  rdy raw csr inf
        step(1, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0, 0,   0,  0,  0,  0,  0);
        // RAW on x5 until its retire has been registered
        step(0, 1, 0, 0, 1, 1,  1, 2,  1,  5,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 1, 5,  1, 1,  1,  6,  0, 0, 0,   0,  0,  1,  0,  1);
        step(0, 1, 0, 0, 1, 5,  1, 1,  1,  6,  0, 0, 0,   0,  0,  1,  0,  1);
        step(0, 1, 0, 0, 1, 5,  1, 1,  1,  6,  1, 1, 5,   0,  0,  1,  0,  1);
        step(0, 1, 0, 0, 1, 5,  1, 1,  1,  6,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 6,   0,  1,  0,  0,  1);
        // x7 counter saturation
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  0, 0, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  0, 0, 0,   0,  1,  0,  0,  2);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  0, 0, 0,   0,  0,  0,  1,  3);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  1, 1, 7,   0,  0,  0,  1,  3);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  7,  0, 0, 0,   0,  1,  0,  0,  2);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 7,   0,  1,  0,  0,  3);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 7,   0,  1,  0,  0,  2);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 7,   0,  1,  0,  0,  1);
        // in-flight limit
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  1,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  2,  0, 0, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  3,  0, 0, 0,   0,  1,  0,  0,  2);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  4,  0, 0, 0,   0,  1,  0,  0,  3);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 10,  0, 0, 0,   0,  0,  0,  1,  4);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 10,  1, 1, 1,   0,  0,  0,  1,  4);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 10,  0, 0, 0,   0,  1,  0,  0,  3);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 2,   0,  0,  0,  0,  4);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 3,   0,  1,  0,  0,  3);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 4,   0,  1,  0,  0,  2);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 10,  0,  1,  0,  0,  1);
        // CSR drain, serialize, release
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 11,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 12,  0, 0, 0,   0,  1,  0,  0,  1);
        step(0, 1, 1, 0, 1, 14, 0, 0,  1, 13,  0, 0, 0,   0,  0,  0,  1,  2);
        step(0, 1, 1, 0, 1, 14, 0, 0,  1, 13,  1, 1, 11,  0,  0,  0,  1,  2);
        step(0, 1, 1, 0, 1, 14, 0, 0,  1, 13,  1, 1, 12,  0,  0,  0,  1,  1);
        step(0, 1, 1, 0, 1, 14, 0, 0,  1, 13,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 1, 16, 0, 0,  1, 15,  0, 0, 0,   0,  0,  0,  1,  1);
        step(0, 1, 0, 0, 1, 16, 0, 0,  1, 15,  1, 1, 13,  1,  0,  0,  1,  1);
        step(0, 1, 0, 0, 1, 16, 0, 0,  1, 15,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 15,  0,  1,  0,  0,  1);
        // x0 never counts
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  0,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  0,  1, 1, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  0,  1, 1, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  0,  1, 1, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 1, 0,  1, 0,  0,  0,  1, 1, 0,   0,  1,  0,  0,  1);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 0, 0,   0,  1,  0,  0,  1);
        // same-cycle issue/retire on x9
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  9,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1,  9,  1, 1, 9,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 1, 9,  0, 0,  0,  0,  0, 0, 0,   0,  0,  1,  0,  1);
        step(0, 1, 0, 0, 1, 9,  0, 0,  0,  0,  1, 1, 9,   0,  0,  1,  0,  1);
        step(0, 1, 0, 0, 1, 9,  0, 0,  0,  0,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 0, 0,   0,  1,  0,  0,  1);
        // reset during DRAIN
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 20,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 21,  0, 0, 0,   0,  1,  0,  0,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 20,  0, 0, 0,   0,  1,  0,  0,  2);
        step(0, 1, 1, 0, 0, 0,  0, 0,  1, 22,  0, 0, 0,   0,  0,  0,  1,  3);
        step(1, 1, 1, 0, 0, 0,  0, 0,  1, 22,  0, 0, 0,   0,  0,  0,  0,  0);
        step(0, 1, 0, 0, 1, 20, 1, 21, 1, 23,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 23,  0,  1,  0,  0,  1);
        // reset during CSR_BUSY, with both stalls active beforehand
        step(0, 1, 1, 0, 0, 0,  0, 0,  1, 24,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 1, 24, 0, 0,  1, 25,  0, 0, 0,   0,  0,  1,  1,  1);
        step(1, 1, 0, 0, 1, 24, 0, 0,  1, 25,  0, 0, 0,   0,  0,  0,  0,  0);
        step(0, 1, 0, 0, 1, 24, 0, 0,  1, 25,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 25,  0,  1,  0,  0,  1);
        // flush leaves DRAIN; flushed instruction does not issue
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 26,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 1, 0, 0, 0,  0, 0,  0,  0,  0, 0, 0,   0,  0,  0,  1,  1);
        step(0, 1, 1, 1, 0, 0,  0, 0,  0,  0,  0, 0, 0,   0,  0,  0,  1,  1);
        step(0, 1, 0, 0, 0, 0,  0, 0,  1, 27,  0, 0, 0,   0,  1,  0,  0,  1);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 26,  0,  1,  0,  0,  2);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 1, 27,  0,  1,  0,  0,  1);
        step(0, 1, 0, 1, 0, 0,  0, 0,  1, 28,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 1, 0, 0, 1, 28, 0, 0,  0,  0,  0, 0, 0,   0,  1,  0,  0,  0);
        step(0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  1, 0, 0,   0,  1,  0,  0,  1);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
